// File: rtl/armleocpu_regfile_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the ArmleoCPU register file.
// Several execution units compete for the single register-file write port;
// a round-robin arbiter picks one per cycle and the winner's write lands
// one cycle later. A 32-entry busy scoreboard tracks destinations that
// decode has claimed but that have not been written back yet.
module armleocpu_regfile_wb_arbiter #(
    parameter int REQ_N = 3
) (
    input  logic                 clk,
    input  logic                 async_rst_n,

    input  logic [REQ_N-1:0]     wb_valid,
    input  logic [REQ_N*5-1:0]   wb_addr,
    input  logic [REQ_N*32-1:0]  wb_data,
    output logic [REQ_N-1:0]     wb_ready,

    output logic                 rd_write,
    output logic [4:0]           rd_addr,
    output logic [31:0]          rd_wdata,

    input  logic                 reserve_valid,
    input  logic [4:0]           reserve_addr,
    output logic                 reserve_ready,
    input  logic                 flush,

    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    localparam int IDX_W = (REQ_N > 2) ? 2 : 1;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             grant_fire;
    logic [4:0]       grant_addr;
    logic [31:0]      grant_data;
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;

    // Round-robin search: first valid requester after last_grant, wrapping.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        for (int k = 1; k <= REQ_N; k++) begin
            for (int i = 0; i < REQ_N; i++) begin
                if (!grant_any && wb_valid[i] &&
                    (((int'(last_grant) + k) % REQ_N) == i)) begin
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

    // No grants while reset is held; a grant is always a transfer because
    // it is only issued to a requester that is already valid.
    assign grant_fire = grant_any && async_rst_n;

    // One-hot ready and mux of the winning requester's address and data.
    always_comb begin
        wb_ready   = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant_fire && (grant_idx == IDX_W'(i))) begin
                wb_ready[i] = 1'b1;
                grant_addr  = wb_addr[5*i +: 5];
                grant_data  = wb_data[32*i +: 32];
            end
        end
    end

    // Write stage: capture the transfer; x0 writes complete but never commit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            last_grant <= IDX_W'(REQ_N - 1);
            rd_write   <= 1'b0;
            rd_addr    <= 5'd0;
            rd_wdata   <= 32'd0;
        end else begin
            rd_write <= grant_fire && (grant_addr != 5'd0);
            if (grant_fire) begin
                last_grant <= grant_idx;
                rd_addr    <= grant_addr;
                rd_wdata   <= grant_data;
            end
        end
    end

    // Claims are judged on registered busy bits only; an in-flight commit
    // does not free its register until the edge it lands on.
    assign reserve_ready = async_rst_n && !flush &&
                           ((reserve_addr == 5'd0) || !busy[reserve_addr]);

    // Scoreboard update priority: flush clears all, a new claim beats a commit.
    always_comb begin
        busy_nxt = busy;
        if (rd_write) begin
            busy_nxt[rd_addr] = 1'b0;
        end
        if (reserve_valid && reserve_ready && (reserve_addr != 5'd0)) begin
            busy_nxt[reserve_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    // NOTE: the 32 busy bits are individual flops that must start clean, so
    // unlike a data RAM they are all reset.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule

// File: tb/tb_armleocpu_regfile_wb_arbiter.sv
// Self-checking bench for armleocpu_regfile_wb_arbiter (REQ_N = 3).
module tb_armleocpu_regfile_wb_arbiter;

    localparam int REQ_N = 3;

    logic                 clk;
    logic                 async_rst_n;
    logic [REQ_N-1:0]     wb_valid;
    logic [REQ_N*5-1:0]   wb_addr;
    logic [REQ_N*32-1:0]  wb_data;
    logic [REQ_N-1:0]     wb_ready;
    logic                 rd_write;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_wdata;
    logic                 reserve_valid;
    logic [4:0]           reserve_addr;
    logic                 reserve_ready;
    logic                 flush;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;

    int n_cmp;
    int n_fail;

    armleocpu_regfile_wb_arbiter #(.REQ_N(REQ_N)) dut (
        .clk           (clk),
        .async_rst_n   (async_rst_n),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .rd_write      (rd_write),
        .rd_addr       (rd_addr),
        .rd_wdata      (rd_wdata),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .reserve_ready (reserve_ready),
        .flush         (flush),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0] valid;
        logic [4:0] a0, a1, a2;
        logic       rv;
        logic [4:0] ra;
        logic       fl;
        logic [4:0] rs1, rs2;
        logic [2:0] e_ready;
        logic       e_rr;
        logic       e_b1, e_b2;
        logic       e_wr;
        logic [4:0] e_addr;
        int         e_src;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic [2:0] valid, logic [4:0] a0, logic [4:0] a1,
                                logic [4:0] a2, logic rv, logic [4:0] ra, logic fl,
                                logic [4:0] rs1, logic [4:0] rs2, logic [2:0] e_ready,
                                logic e_rr, logic e_b1, logic e_b2, logic e_wr,
                                logic [4:0] e_addr, int e_src);
        vec_t v;
        v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.rv = rv; v.ra = ra; v.fl = fl; v.rs1 = rs1; v.rs2 = rs2;
        v.e_ready = e_ready; v.e_rr = e_rr; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_src = e_src;
        return v;
    endfunction

    // Data each requester presents: tagged with requester number and address.
    function automatic logic [31:0] data_of(int src, logic [4:0] a);
        return 32'hC0DE_0000 | (32'(src) << 8) | 32'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_wb(input logic [2:0] valid, input logic [4:0] a0,
                            input logic [4:0] a1, input logic [4:0] a2);
        wb_valid = valid;
        wb_addr  = {a2, a1, a0};
        wb_data  = {data_of(2, a2), data_of(1, a1), data_of(0, a0)};
    endtask

    task automatic drive_sb(input logic rv, input logic [4:0] ra, input logic fl,
                            input logic [4:0] r1, input logic [4:0] r2);
        reserve_valid = rv;
        reserve_addr  = ra;
        flush         = fl;
        rs1_addr      = r1;
        rs2_addr      = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset: outputs forced low independent of clock and inputs.
        async_rst_n = 1'b0;
        drive_wb(3'b111, 5'd1, 5'd2, 5'd3);
        drive_sb(1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
        #2;
        check("rst_wb_ready", 32'(wb_ready), 32'h0);
        check("rst_reserve_ready", 32'(reserve_ready), 32'h0);
        check("rst_rd_write", 32'(rd_write), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_rd_wdata", rd_wdata, 32'h0);
        check("rst_rs1_busy", 32'(rs1_busy), 32'h0);
        step();
        check("rst_clk_rd_write", 32'(rd_write), 32'h0);
        async_rst_n = 1'b1;
        drive_sb(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        // Round-robin rotation, hold of write outputs, scoreboard basics.
        vecs[0]  = mk(3'b111, 1, 2, 3, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 1, 1, 0);
        vecs[1]  = mk(3'b111, 1, 2, 3, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 1, 2, 1);
        vecs[2]  = mk(3'b111, 1, 2, 3, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 1, 3, 2);
        vecs[3]  = mk(3'b111, 1, 2, 3, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 1, 1, 0);
        vecs[4]  = mk(3'b101, 1, 2, 3, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 1, 3, 2);
        vecs[5]  = mk(3'b000, 1, 2, 3, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 3, 2);
        vecs[6]  = mk(3'b010, 1, 2, 3, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 1, 2, 1);
        vecs[7]  = mk(3'b011, 1, 2, 3, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 1, 1, 0);
        vecs[8]  = mk(3'b110, 1, 2, 3, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0, 1, 2, 1);
        vecs[9]  = mk(3'b110, 1, 2, 3, 0, 0, 0, 0, 0, 3'b100, 1, 0, 0, 1, 3, 2);
        vecs[10] = mk(3'b000, 1, 2, 3, 1, 5, 0, 5, 6, 3'b000, 1, 0, 0, 0, 3, 2);
        vecs[11] = mk(3'b000, 1, 2, 3, 1, 6, 0, 5, 6, 3'b000, 1, 1, 0, 0, 3, 2);
        vecs[12] = mk(3'b000, 1, 2, 3, 1, 5, 0, 5, 6, 3'b000, 0, 1, 1, 0, 3, 2);
        vecs[13] = mk(3'b000, 1, 2, 3, 1, 7, 1, 5, 6, 3'b000, 0, 1, 1, 0, 3, 2);
        vecs[14] = mk(3'b000, 1, 2, 3, 0, 7, 0, 5, 7, 3'b000, 1, 0, 0, 0, 3, 2);

        for (int v = 0; v < 15; v++) begin
            drive_wb(vecs[v].valid, vecs[v].a0, vecs[v].a1, vecs[v].a2);
            drive_sb(vecs[v].rv, vecs[v].ra, vecs[v].fl, vecs[v].rs1, vecs[v].rs2);
            #1;
            check($sformatf("v%0d_wb_ready", v), 32'(wb_ready), 32'(vecs[v].e_ready));
            check($sformatf("v%0d_reserve_ready", v), 32'(reserve_ready), 32'(vecs[v].e_rr));
            check($sformatf("v%0d_rs1_busy", v), 32'(rs1_busy), 32'(vecs[v].e_b1));
            check($sformatf("v%0d_rs2_busy", v), 32'(rs2_busy), 32'(vecs[v].e_b2));
            step();
            check($sformatf("v%0d_rd_write", v), 32'(rd_write), 32'(vecs[v].e_wr));
            check($sformatf("v%0d_rd_addr", v), 32'(rd_addr), 32'(vecs[v].e_addr));
            check($sformatf("v%0d_rd_wdata", v), rd_wdata, data_of(vecs[v].e_src, vecs[v].e_addr));
        end
        drive_sb(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        // Claim x5, then requester 1 writes it back; busy drops after the commit edge.
        drive_sb(1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
        #1;
        check("x5_reserve_ready", 32'(reserve_ready), 32'h1);
        step();
        drive_sb(1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        drive_wb(3'b010, 5'd0, 5'd5, 5'd0);
        wb_data[63:32] = 32'hDEAD_BEEF;
        #1;
        check("x5_rs1_busy_claimed", 32'(rs1_busy), 32'h1);
        check("x5_wb_ready", 32'(wb_ready), 32'h2);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        check("x5_rd_write", 32'(rd_write), 32'h1);
        check("x5_rd_addr", 32'(rd_addr), 32'd5);
        check("x5_rd_wdata", rd_wdata, 32'hDEAD_BEEF);
        check("x5_rs1_busy_inflight", 32'(rs1_busy), 32'h1);
        step();
        check("x5_rs1_busy_after", 32'(rs1_busy), 32'h0);
        check("x5_rd_write_drop", 32'(rd_write), 32'h0);

        // x7 busy: claims rejected even while its commit is in flight.
        drive_sb(1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        step();
        drive_wb(3'b001, 5'd7, 5'd0, 5'd0);
        #1;
        check("x7_reserve_busy", 32'(reserve_ready), 32'h0);
        check("x7_wb_ready", 32'(wb_ready), 32'h1);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        check("x7_rd_write", 32'(rd_write), 32'h1);
        check("x7_rd_addr", 32'(rd_addr), 32'd7);
        check("x7_reserve_commit_same_cycle", 32'(reserve_ready), 32'h0);
        step();
        drive_sb(1'b0, 5'd7, 1'b0, 5'd7, 5'd0);
        #1;
        check("x7_reserve_after_commit", 32'(reserve_ready), 32'h1);
        check("x7_rs1_busy_after", 32'(rs1_busy), 32'h0);

        // Commit x9 and claim x9 on the same edge: the claim wins.
        drive_wb(3'b100, 5'd0, 5'd0, 5'd9);
        #1;
        check("x9_wb_ready", 32'(wb_ready), 32'h4);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        drive_sb(1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        #1;
        check("x9_rd_write", 32'(rd_write), 32'h1);
        check("x9_reserve_ready", 32'(reserve_ready), 32'h1);
        check("x9_rs1_busy_before", 32'(rs1_busy), 32'h0);
        step();
        drive_sb(1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        #1;
        check("x9_rs1_busy_set_wins", 32'(rs1_busy), 32'h1);

        // Claim x3, x4; commit x3 in flight while flush clears everything.
        drive_sb(1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
        step();
        drive_sb(1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
        drive_wb(3'b001, 5'd3, 5'd0, 5'd0);
        #1;
        check("fl_wb_ready_x3", 32'(wb_ready), 32'h1);
        step();
        drive_sb(1'b1, 5'd6, 1'b1, 5'd3, 5'd4);
        drive_wb(3'b010, 5'd0, 5'd8, 5'd0);
        #1;
        check("fl_rd_write_x3", 32'(rd_write), 32'h1);
        check("fl_rd_addr_x3", 32'(rd_addr), 32'd3);
        check("fl_reserve_rejected", 32'(reserve_ready), 32'h0);
        check("fl_wb_ready_during", 32'(wb_ready), 32'h2);
        check("fl_rs1_busy_x3", 32'(rs1_busy), 32'h1);
        check("fl_rs2_busy_x4", 32'(rs2_busy), 32'h1);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        drive_sb(1'b0, 5'd0, 1'b0, 5'd3, 5'd6);
        #1;
        check("fl_rd_write_x8", 32'(rd_write), 32'h1);
        check("fl_rd_addr_x8", 32'(rd_addr), 32'd8);
        check("fl_rd_wdata_x8", rd_wdata, data_of(1, 5'd8));
        check("fl_rs1_busy_x3_clr", 32'(rs1_busy), 32'h0);
        check("fl_rs2_busy_x6_clr", 32'(rs2_busy), 32'h0);
        drive_sb(1'b0, 5'd0, 1'b0, 5'd4, 5'd9);
        #1;
        check("fl_rs1_busy_x4_clr", 32'(rs1_busy), 32'h0);
        check("fl_rs2_busy_x9_clr", 32'(rs2_busy), 32'h0);
        step();

        // Write to x0: handshake completes, no commit, x0 never busy.
        drive_wb(3'b001, 5'd0, 5'd0, 5'd0);
        wb_data[31:0] = 32'h0000_1234;
        drive_sb(1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        check("x0_wb_ready", 32'(wb_ready), 32'h1);
        check("x0_reserve_ready", 32'(reserve_ready), 32'h1);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        drive_sb(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        check("x0_rd_write", 32'(rd_write), 32'h0);
        check("x0_rs1_busy", 32'(rs1_busy), 32'h0);

        // Reset in the middle of a pending write drops it and clears claims.
        drive_wb(3'b100, 5'd0, 5'd0, 5'd10);
        drive_sb(1'b1, 5'd11, 1'b0, 5'd11, 5'd0);
        #1;
        check("mr_wb_ready", 32'(wb_ready), 32'h4);
        step();
        check("mr_rd_write_pending", 32'(rd_write), 32'h1);
        drive_wb(3'b111, 5'd1, 5'd2, 5'd3);
        drive_sb(1'b1, 5'd0, 1'b0, 5'd11, 5'd0);
        #1;
        async_rst_n = 1'b0;
        #1;
        check("mr_rd_write", 32'(rd_write), 32'h0);
        check("mr_rd_addr", 32'(rd_addr), 32'h0);
        check("mr_rd_wdata", rd_wdata, 32'h0);
        check("mr_wb_ready", 32'(wb_ready), 32'h0);
        check("mr_reserve_ready", 32'(reserve_ready), 32'h0);
        check("mr_rs1_busy", 32'(rs1_busy), 32'h0);
        step();
        drive_sb(1'b0, 5'd0, 1'b0, 5'd11, 5'd0);
        async_rst_n = 1'b1;
        #1;
        check("mr_release_wb_ready", 32'(wb_ready), 32'h1);
        check("mr_release_rd_write", 32'(rd_write), 32'h0);
        step();
        drive_wb(3'b000, 5'd0, 5'd0, 5'd0);
        check("mr_first_rd_write", 32'(rd_write), 32'h1);
        check("mr_first_rd_addr", 32'(rd_addr), 32'd1);
        check("mr_first_rd_wdata", rd_wdata, data_of(0, 5'd1));
        check("mr_rs1_busy_after", 32'(rs1_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/armleocpu_regfile_wb_arbiter.md
ARMLEOCPU_REGFILE_WB_ARBITER -- requirements
Module: armleocpu_regfile_wb_arbiter

Interface
REQ-001 Parameter REQ_N, default 3, number of write-back requesters; legal range 2..4.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 async_rst_n  input  1  asynchronous active-low reset.
REQ-004 wb_valid  input  REQ_N  per-requester write-back request.
REQ-005 wb_addr  input  REQ_N*5  destination register per requester; requester i at bits [5i+4:5i].
REQ-006 wb_data  input  REQ_N*32  write data per requester; requester i at bits [32i+31:32i].
REQ-007 wb_ready  output  REQ_N  per-requester grant; one-hot or zero.
REQ-008 rd_write  output  1  registered write enable to the register file.
REQ-009 rd_addr  output  5  registered write address.
REQ-010 rd_wdata  output  32  registered write data.
REQ-011 reserve_valid  input  1  decode claims a destination register.
REQ-012 reserve_addr  input  5  register being claimed.
REQ-013 reserve_ready  output  1  claim accepted this cycle.
REQ-014 flush  input  1  pipeline kill; clears all claims.
REQ-015 rs1_addr, rs2_addr  input  5 each  source registers to hazard-check.
REQ-016 rs1_busy, rs2_busy  output  1 each  source has a pending write.

Function
REQ-017 Request handshake: transfer on wb_valid[i] && wb_ready[i]; requester SHALL hold valid, addr, data stable until transfer.
REQ-018 wb_ready SHALL be combinational; at most one bit set per cycle; zero when no wb_valid set.
REQ-019 Arbitration SHALL be round-robin: search starts at requester (last_grant+1) mod REQ_N; last_grant updates only on a transfer.
REQ-020 Write stage accepts every cycle (no back-pressure); transfer at cycle N SHALL drive rd_write=1, rd_addr, rd_wdata in cycle N+1 for exactly one cycle.
REQ-021 Transfer with addr 0 SHALL complete handshake but drive rd_write=0 in cycle N+1.
REQ-022 No transfer in cycle N SHALL give rd_write=0 in N+1; rd_addr/rd_wdata hold previous values.
REQ-023 Scoreboard: 32 busy bits; bit 0 SHALL read 0 always.
REQ-024 reserve_ready SHALL equal !flush && (reserve_addr==0 || !busy[reserve_addr]); combinational, ignoring same-cycle commits.
REQ-025 reserve_valid && reserve_ready with nonzero addr SHALL set busy[reserve_addr] at next edge.
REQ-026 Commit (rd_write=1) SHALL clear busy[rd_addr] at the same edge the write lands, unless set by REQ-025 on that edge (set wins).
REQ-027 Commit to a non-busy register is legal and leaves scoreboard unchanged.
REQ-028 rsX_busy SHALL equal busy[rsX_addr] (registered bits, combinational select); no bypass of the commit in flight.
REQ-029 flush SHALL clear all busy bits at next edge; in-flight rd_write commit and arbitration continue unaffected.
REQ-030 flush and reserve_valid same cycle: reserve rejected (reserve_ready=0), all bits cleared.

Reset
REQ-031 While async_rst_n=0: rd_write=0, rd_addr=0, rd_wdata=0, all busy=0, last_grant=REQ_N-1 (requester 0 first), independent of clk.
REQ-032 wb_ready SHALL be 0 while reset asserted; reserve_ready SHALL be 0 while reset asserted.
REQ-033 Reset mid-transfer SHALL drop the pending write (rd_write=0 after release); first edge after release behaves as post-reset.

Verification
REQ-034 All 3 valid continuously, addrs 1,2,3 -> grants 0,1,2,0,1,2...; rd_addr 1,2,3,... one cycle after each grant.
REQ-035 Reserve x5, then rs1_addr=5 -> rs1_busy=1; requester 1 writes x5=0xDEADBEEF -> rd_write next cycle, rs1_busy=0 the cycle after.
REQ-036 x7 busy; reserve x7 -> reserve_ready=0; same cycle commit x7 -> still rejected; next cycle reserve_ready=1.
REQ-037 Commit x9 and reserve x9 same edge (x9 not busy) -> busy[9]=1 after edge.
REQ-038 Reserve x3, x4; flush with reserve x6 -> all busy 0, x6 not claimed; pending commit to x3 still writes.
REQ-039 Write x0=0x1234 -> wb_ready=1, rd_write stays 0; reserve x0 -> reserve_ready=1, rs1_busy for x0 stays 0.
